// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM encoding and
// frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_e;

  // Total serial bits in one frame: start + data + optional parity + stop.
  function automatic int frameBits(input int dataW, input int parity, input int stopBits);
    return 1 + dataW + ((parity != PAR_NONE) ? 1 : 0) + stopBits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always presented on o_rdata
// and a push is accepted while full if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      level_q, level_d;
  logic             pushOk, popOk;

  assign popOk  = i_pop && (level_q != '0);
  assign pushOk = i_push && ((level_q != LVL_FULL) || popOk);

  always_comb begin
    level_d = level_q;
    if (pushOk && !popOk) begin
      level_d = level_q + LVL_ONE;
    end else if (popOk && !pushOk) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Storage is cleared on reset so the head reads as zero when empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= i_wdata;
        wrPtr_q        <= wrPtr_q + PTR_ONE;
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      level_q <= level_d;
    end
  end

  assign o_rdata = mem_q[rdPtr_q];
  assign o_full  = (level_q == LVL_FULL);
  assign o_empty = (level_q == '0);
  assign o_level = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, configurable frame format,
// break detection and a show-ahead receive FIFO carrying per-frame error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rxd,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam int EW = DATA_W + 2;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic              sync1_q, sync2_q, rxS;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        samp_q, samp_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bitIdx_q, bitIdx_d;
  logic              stopIdx_q, stopIdx_d;
  logic              parBit_q, parBit_d;
  logic              parErr_q, parErr_d;
  logic              frameErr_q, frameErr_d;
  logic              maj, decide, bitLast;
  logic              push, pushFrameErr;
  logic [EW-1:0]     pushEntry, headEntry;
  logic              fifoFull, fifoEmpty;

  // Two-flop synchroniser; idles high so reset does not fake a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxS     = sync2_q;
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxS) | (samp_q[1] & rxS);
  assign decide  = (cnt_q == CNT_DEC);
  assign bitLast = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      stopIdx_q  <= 1'b0;
      parBit_q   <= 1'b0;
      parErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      stopIdx_q  <= stopIdx_d;
      parBit_q   <= parBit_d;
      parErr_q   <= parErr_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = bitLast ? '0 : cnt_q + CNT_ONE;
    samp_d       = samp_q;
    shift_d      = shift_q;
    bitIdx_d     = bitIdx_q;
    stopIdx_d    = stopIdx_q;
    parBit_d     = parBit_q;
    parErr_d     = parErr_q;
    frameErr_d   = frameErr_q;
    push         = 1'b0;
    pushFrameErr = frameErr_q;

    if (cnt_q == CNT_S0) samp_d[0] = rxS;
    if (cnt_q == CNT_S1) samp_d[1] = rxS;

    unique case (state_q)
      ST_IDLE: begin
        // The cycle that sees the low level is count 0 of the start bit.
        cnt_d = CNT_ONE;
        if (!rxS) begin
          state_d    = ST_START;
          bitIdx_d   = '0;
          stopIdx_d  = 1'b0;
          parBit_d   = 1'b0;
          parErr_d   = 1'b0;
          frameErr_d = 1'b0;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (bitLast) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_W-1:1]};
        if (bitLast) begin
          if (bitIdx_q == BIT_LAST) begin
            bitIdx_d = '0;
            state_d  = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + BIT_ONE;
          end
        end
      end
      ST_PAR: begin
        if (decide) begin
          parBit_d = maj;
          parErr_d = (PARITY == PAR_EVEN) ? ((^shift_q) ^ maj) : ~((^shift_q) ^ maj);
        end
        if (bitLast) state_d = ST_STOP;
      end
      ST_STOP: begin
        // A break is an all-zero frame whose first stop bit is also low.
        if (decide) begin
          if (!stopIdx_q && !maj && (shift_q == '0) && !parBit_q) begin
            push         = 1'b1;
            pushFrameErr = 1'b1;
            state_d      = ST_BRK;
          end else if (stopIdx_q == STOP_LAST) begin
            push         = 1'b1;
            pushFrameErr = frameErr_q | ~maj;
            state_d      = ST_IDLE;
          end else begin
            frameErr_d = frameErr_q | ~maj;
          end
        end
        if (bitLast) stopIdx_d = ~stopIdx_q;
      end
      ST_BRK: begin
        if (rxS) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pushEntry = {parErr_q, pushFrameErr, shift_q};

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (pushEntry),
    .i_pop   (i_ready),
    .o_rdata (headEntry),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty),
    .o_level (o_level)
  );

  assign o_data       = headEntry[DATA_W-1:0];
  assign o_frame_err  = headEntry[DATA_W];
  assign o_parity_err = headEntry[DATA_W+1];
  assign o_valid      = !fifoEmpty;
  assign o_overrun    = push && fifoFull && !(o_valid && i_ready) && !i_rst;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised by a bit driver and
// expected FIFO entries are queued as they are sent, then compared on pop.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 5;
  localparam int DW    = 8;
  localparam int PARM  = PAR_EVEN;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
  localparam int M     = CPB / 2;
  localparam int NBITS = frameBits(DW, PARM, SB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          pe, fe, valid, overrun;
  logic [$clog2(DEPTH):0] level;

  int errors = 0;
  int checks = 0;
  int ovTotal = 0;
  logic [DW+1:0] expQ[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(DW),
    .PARITY(PARM),
    .STOP_BITS(SB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rxd        (rxd),
    .o_data       (data),
    .o_parity_err (pe),
    .o_frame_err  (fe),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_overrun    (overrun),
    .o_level      (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ovTotal++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic evenPar(input logic [DW-1:0] d);
    return ^d;
  endfunction

  // All driving tasks start and end one time unit after a rising edge.
  task automatic driveBit(input logic b, input int glitchCyc);
    for (int c = 0; c < CPB; c++) begin
      rxd = (c == glitchCyc) ? ~b : b;
      @(posedge clk); #1;
    end
  endtask

  task automatic sendFrame(input logic [DW-1:0] d, input logic pbit, input logic sbit, input int glitchBit);
    logic [NBITS-1:0] bits;
    bits = {sbit, pbit, d, 1'b0};
    for (int i = 0; i < NBITS; i++) begin
      driveBit(bits[i], (i == glitchBit) ? M : -1);
    end
    rxd = 1'b1;
  endtask

  task automatic idleBits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic popOne();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    checks++; if (data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 00", data); end
    checks++; if (pe !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err: got %b want 0", pe); end
    checks++; if (fe !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b want 0", fe); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    @(posedge clk); #1;
  endtask

  task automatic test_valid_frame();
    int waitCyc;
    bit seen;
    int expCyc;
    logic [DW+1:0] e;
    expCyc = (NBITS - 1) * CPB + M + 1 + 4;
    expQ.push_back({1'b0, 1'b0, 8'hA5});
    waitCyc = 0;
    seen = 1'b0;
    fork
      sendFrame(8'hA5, evenPar(8'hA5), 1'b1, -1);
      begin
        while (!seen && waitCyc < 100) begin
          @(negedge clk);
          waitCyc++;
          if (valid === 1'b1) seen = 1'b1;
        end
      end
    join
    checks++; if (!seen || waitCyc != expCyc) begin errors++; $display("[TB] FAIL valid_latency: got %0d cycles (seen=%0d) want %0d", waitCyc, seen, expCyc); end
    @(posedge clk); #1;
    @(negedge clk);
    e = expQ.pop_front();
    checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL valid_entry: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL valid_level: got %0d want 1", level); end
    @(posedge clk); #1;
    popOne();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_popped: got %b want 0", valid); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL valid_level_after_pop: got %0d want 0", level); end
    @(posedge clk); #1;
  endtask

  task automatic test_parity_error();
    logic [DW+1:0] e;
    sendFrame(8'h3C, ~evenPar(8'h3C), 1'b1, -1);
    expQ.push_back({1'b1, 1'b0, 8'h3C});
    sendFrame(8'h01, evenPar(8'h01), 1'b0, -1);
    expQ.push_back({1'b0, 1'b1, 8'h01});
    idleBits(2);
    checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL parity_level: got %0d want 2", level); end
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL parity_entry: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
      @(posedge clk); #1;
      popOne();
    end
  endtask

  task automatic test_glitch();
    logic [DW+1:0] e;
    rxd = 1'b0;
    @(posedge clk); #1;
    idleBits(4);
    @(negedge clk);
    checks++; if (level !== '0 || valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_idle: got level=%0d valid=%b want 0/0", level, valid); end
    @(posedge clk); #1;
    sendFrame(8'h55, evenPar(8'h55), 1'b1, 4);
    expQ.push_back({1'b0, 1'b0, 8'h55});
    idleBits(1);
    @(negedge clk);
    e = expQ.pop_front();
    checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL glitch_data: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
    @(posedge clk); #1;
    popOne();
  endtask

  task automatic test_back_to_back_overrun();
    logic [DW-1:0] d;
    logic [DW+1:0] e;
    int base;
    ready = 1'b0;
    base = ovTotal;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(17 * i);
      sendFrame(d, evenPar(d), 1'b1, -1);
      expQ.push_back({1'b0, 1'b0, d});
    end
    idleBits(1);
    checks++; if (level !== 3'd4 || ovTotal != base) begin errors++; $display("[TB] FAIL overrun_pre: got level=%0d overruns=%0d want 4/0", level, ovTotal - base); end
    sendFrame(8'h55, evenPar(8'h55), 1'b1, -1);
    idleBits(1);
    checks++; if (ovTotal - base != 1) begin errors++; $display("[TB] FAIL overrun_pulse: got %0d pulses want 1", ovTotal - base); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL overrun_level: got %0d want 4", level); end
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL overrun_order: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
      @(posedge clk); #1;
      popOne();
    end
    @(negedge clk);
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL overrun_drained: got %0d want 0", level); end
    @(posedge clk); #1;
  endtask

  task automatic test_break();
    logic [DW+1:0] e;
    rxd = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    expQ.push_back({1'b0, 1'b1, 8'h00});
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL break_single: got level=%0d want 1", level); end
    idleBits(2);
    sendFrame(8'h7E, evenPar(8'h7E), 1'b1, -1);
    expQ.push_back({1'b0, 1'b0, 8'h7E});
    idleBits(1);
    checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL break_level: got %0d want 2", level); end
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL break_entry: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
      @(posedge clk); #1;
      popOne();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] partial;
    logic [DW+1:0] e;
    partial = 8'h0F;
    sendFrame(8'hA1, evenPar(8'hA1), 1'b1, -1);
    sendFrame(8'hB2, evenPar(8'hB2), 1'b1, -1);
    idleBits(1);
    checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL rstmid_queued: got %0d want 2", level); end
    driveBit(1'b0, -1);
    for (int i = 0; i < 4; i++) driveBit(partial[i], -1);
    rxd = partial[4];
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    checks++; if ({valid, pe, fe, overrun} !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_flags: got v=%b pe=%b fe=%b ov=%b want 0000", valid, pe, fe, overrun); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL rstmid_level: got %0d want 0", level); end
    checks++; if (data !== '0) begin errors++; $display("[TB] FAIL rstmid_data: got %h want 00", data); end
    @(posedge clk); #1;
    idleBits(2);
    sendFrame(8'hC3, evenPar(8'hC3), 1'b1, -1);
    expQ.push_back({1'b0, 1'b0, 8'hC3});
    idleBits(1);
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_after_level: got %0d want 1", level); end
    @(negedge clk);
    e = expQ.pop_front();
    checks++; if ({valid, pe, fe, data} !== {1'b1, e}) begin errors++; $display("[TB] FAIL rstmid_after_entry: got v=%b pe=%b fe=%b d=%h want v=1 entry=%h", valid, pe, fe, data, e); end
    @(posedge clk); #1;
    popOne();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_glitch();
    test_back_to_back_overrun();
    test_break();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver, successor to the fixed 8-bit `receive` block. It adds configurable data width, parity and stop bits, plus 3-sample majority voting, break detection and a show-ahead receive FIFO with valid/ready output. It sits between the serial line (e.g. `UART_wrapper`'s `o_txd`) and any byte consumer, and reports per-frame error flags alongside each word.

## Interface
- `CLKS_PER_BIT`, 5: clocks per serial bit; legal range ≥ 4.
- `DATA_W`, 8: data bits per frame; legal range 5–9.
- `PARITY`, 0: parity mode; 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rxd`  in  1  asynchronous serial input; idles high.
- `o_data`  out  DATA_W  FIFO head data, LSB = first bit received.
- `o_parity_err`  out  1  head entry parity mismatch.
- `o_frame_err`  out  1  head entry had a stop bit sampled 0, or was a break.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  consumer accepts the head; pop when `o_valid && i_ready`.
- `o_overrun`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- `i_rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- Bit counter runs 0..CLKS_PER_BIT-1 within each bit. Let M = CLKS_PER_BIT/2, using integer division.
- Samples are taken at counts M-1, M and M+1. The bit value is the majority of the 3 samples and is decided at count M+1.
- IDLE: the first synchronised 0 moves to START, with the counter set to 1 on entry. The cycle that saw the 0 is count 0.
- START: a majority of 1 is a false start and returns to IDLE at the decision cycle. Otherwise continue; at count CLKS_PER_BIT-1 go to DATA.
- DATA: shifts DATA_W bits, LSB first. Goes to PAR if PARITY≠0, else to STOP.
- PAR: computes the error flag. Even mode: XOR of data and parity bit ≠ 0. Odd mode: XOR = 0.
- STOP: samples STOP_BITS bits; any 0 sets the frame error.
  - At the decision of the last stop bit, the frame is pushed and the FSM goes to IDLE that same cycle.
  - Going to IDLE mid-stop-bit allows back-to-back frames.
- Break: if data are all 0, parity (if present) is 0 and the first stop bit is 0, push the entry with frame_err=1 and go to BRK. BRK returns to IDLE after 1 synchronised high sample.
- FIFO entry is {parity_err, frame_err, data}.
- If the FIFO is full at push time, the frame is discarded and `o_overrun` pulses in that cycle. The exception: a pop in the same cycle frees a slot, so the push is accepted and there is no overrun.
- Stored entries are never overwritten.

## Timing
- Reset values: FSM IDLE, FIFO empty, `o_valid`=0, `o_level`=0, `o_data`=0, `o_parity_err`=0, `o_frame_err`=0, `o_overrun`=0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- `i_rxd` to FSM latency: 2 cycles (synchroniser).
- Push to `o_valid`/`o_data` visible: next cycle. The FIFO is show-ahead and outputs are registered from FIFO storage.
- Pop: the head advances the cycle after `o_valid && i_ready`. `o_level` updates the same cycle.
- Simultaneous push and pop: `o_level` is unchanged and order is preserved.
- Outputs are stable while `o_valid && !i_ready`.
- Frame of N = 1 + DATA_W + (PARITY≠0) + STOP_BITS bits: push occurs (N-1)·CLKS_PER_BIT + M+1 cycles after the START-entry count-0 cycle.

## Structure
- Package `uart_pkg` holds:
  - the parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the FSM state encoding;
  - a function for the frame bit count N.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): show-ahead, with full/empty and level outputs, and push/pop accepted in the same cycle when full.
- The top contains the synchroniser, FSM, counters, majority vote and shift register.

## Test plan
All cases use CLKS_PER_BIT=5, DATA_W=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4, with frames driven by a bench bit-driver.
- **Valid frame:** send 0xA5 with even parity bit 0 → `o_valid` rises; `o_data`=0xA5, `o_parity_err`=0, `o_frame_err`=0. Pop with `i_ready`=1 → `o_valid`=0, `o_level`=0.
- **Parity error:** send 0x3C with parity bit 1 → `o_data`=0x3C, `o_parity_err`=1. Then send 0x01 with stop bit 0 → `o_frame_err`=1.
- **Glitch rejection:**
  - A 1-cycle low pulse on an idle line → no push, `o_level`=0.
  - A 1-cycle inverted glitch at count M inside data bit 3 of 0x55 → received as 0x55.
- **Overrun and ordering:** with `i_ready`=0, send 0x11, 0x22, 0x33, 0x44, 0x55 → `o_level`=4 and one `o_overrun` pulse on frame 5. Draining gives 0x11..0x44 in order.
- **Break:** hold the line low for 30 bit times → exactly one entry with data 0x00 and `o_frame_err`=1. No further entries until the line goes high, then 0x7E is received cleanly.
- **Reset mid-frame:** assert `i_rst` for 1 cycle during data bit 4, with 2 entries queued → all outputs at reset values next cycle. The next frame 0xC3 is received correctly.
